// File: rtl/restoring_divider_seq.sv
// Sequential restoring divider. It produces one quotient bit per clock and supports
// an optional two's-complement mode, plus divide-by-zero and overflow flags.
module restoring_divider_seq #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [DIVIDEND_W-1:0]   a;
  logic [DIVISOR_W-1:0]    b;
  logic [DIVISOR_W:0]      p;
  logic                    neg_q, neg_r, smode, zero_div;
  logic [DIVISOR_W+1:0]    trial;
  logic                    trial_ok;

  assign busy = (state != IDLE);

  // The trial keeps p's top bit, so the sign of the difference is unambiguous.
  assign trial    = {p, a[DIVIDEND_W-1]} - {2'b00, b};
  assign trial_ok = ~trial[DIVISOR_W+1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? FIX : CALC;
      CALC: if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      a           <= '0;
      b           <= '0;
      p           <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      smode       <= 1'b0;
      zero_div    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Work on magnitudes; the most negative value maps onto its own unsigned pattern.
            smode    <= signed_mode;
            neg_q    <= signed_mode & (dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1]);
            neg_r    <= signed_mode & dividend[DIVIDEND_W-1];
            a        <= (signed_mode && dividend[DIVIDEND_W-1]) ? (~dividend + 1'b1) : dividend;
            b        <= (signed_mode && divisor[DIVISOR_W-1]) ? (~divisor + 1'b1) : divisor;
            p        <= '0;
            cnt      <= CNT_INIT;
            zero_div <= (divisor == '0);
          end
        end
        CALC: begin
          p   <= trial_ok ? trial[DIVISOR_W:0] : {p[DIVISOR_W-1:0], a[DIVIDEND_W-1]};
          a   <= {a[DIVIDEND_W-2:0], trial_ok};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            quotient    <= neg_q ? (~a + 1'b1) : a;
            remainder   <= neg_r ? (~p[DIVISOR_W-1:0] + 1'b1) : p[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
            // A positive signed result whose magnitude reaches the sign bit cannot be represented.
            overflow    <= smode & ~neg_q & a[DIVIDEND_W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Directed bench for restoring_divider_seq. It drives the default 8/4 instance and a
// 16/8 instance, and compares against hand-computed quotients, remainders and latencies.
module tb_restoring_divider_seq;

  logic        clk = 1'b0;
  logic        rst, start, signed_mode;
  logic [7:0]  dividend;
  logic [3:0]  divisor;
  logic        busy, done, div_by_zero, overflow;
  logic [7:0]  quotient;
  logic [3:0]  remainder;

  logic        start_w, signed_mode_w;
  logic [15:0] dividend_w;
  logic [7:0]  divisor_w;
  logic        busy_w, done_w, div_by_zero_w, overflow_w;
  logic [15:0] quotient_w;
  logic [7:0]  remainder_w;

  int checks = 0;
  int errors = 0;
  int lat, busy_bad, done_seen;

  always #5 clk = ~clk;

  restoring_divider_seq dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  restoring_divider_seq #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .signed_mode(signed_mode_w),
    .dividend(dividend_w), .divisor(divisor_w), .busy(busy_w), .done(done_w),
    .quotient(quotient_w), .remainder(remainder_w),
    .div_by_zero(div_by_zero_w), .overflow(overflow_w)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sm, input logic [7:0] dvd, input logic [3:0] dvs);
    signed_mode = sm;
    dividend    = dvd;
    divisor     = dvs;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic applyStimulusWide(input logic sm, input logic [15:0] dvd, input logic [7:0] dvs);
    signed_mode_w = sm;
    dividend_w    = dvd;
    divisor_w     = dvs;
    start_w       = 1'b1;
    tick();
    start_w       = 1'b0;
  endtask

  // Counts edges until done, noting any cycle in which busy dropped early.
  task automatic waitDone(output int l, output int bb);
    l  = 0;
    bb = 0;
    while (done !== 1'b1 && l < 40) begin
      if (busy !== 1'b1) bb++;
      tick();
      l++;
    end
  endtask

  task automatic waitDoneWide(output int l, output int bb);
    l  = 0;
    bb = 0;
    while (done_w !== 1'b1 && l < 60) begin
      if (busy_w !== 1'b1) bb++;
      tick();
      l++;
    end
  endtask

  task automatic runOp(input string tag, input logic sm, input logic [7:0] dvd, input logic [3:0] dvs,
                       input logic [7:0] eq, input logic [3:0] er, input logic edz, input logic eov,
                       input int elat);
    int l, bb;
    applyStimulus(sm, dvd, dvs);
    waitDone(l, bb);
    checkOutput({tag, "_latency"}, l, elat);
    checkOutput({tag, "_busy_during"}, bb, 0);
    checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
    checkOutput({tag, "_q"}, quotient, eq);
    checkOutput({tag, "_r"}, remainder, er);
    checkOutput({tag, "_dz"}, div_by_zero, edz);
    checkOutput({tag, "_ov"}, overflow, eov);
    tick();
    checkOutput({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic runOpWide(input string tag, input logic sm, input logic [15:0] dvd, input logic [7:0] dvs,
                           input logic [15:0] eq, input logic [7:0] er, input logic edz, input logic eov,
                           input int elat);
    int l, bb;
    applyStimulusWide(sm, dvd, dvs);
    waitDoneWide(l, bb);
    checkOutput({tag, "_latency"}, l, elat);
    checkOutput({tag, "_busy_during"}, bb, 0);
    checkOutput({tag, "_q"}, quotient_w, eq);
    checkOutput({tag, "_r"}, remainder_w, er);
    checkOutput({tag, "_dz"}, div_by_zero_w, edz);
    checkOutput({tag, "_ov"}, overflow_w, eov);
    tick();
    checkOutput({tag, "_done_pulse"}, done_w, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    start_w = 1'b0; signed_mode_w = 1'b0; dividend_w = '0; divisor_w = '0;
    tick();
    tick();
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_q", quotient, 8'h00);
    checkOutput("reset_r", remainder, 4'h0);
    checkOutput("reset_dz", div_by_zero, 1'b0);
    checkOutput("reset_ov", overflow, 1'b0);
    rst = 1'b0;
    tick();

    runOp("u_0d_5", 1'b0, 8'h0D, 4'h5, 8'h02, 4'h3, 1'b0, 1'b0, 9);
    runOp("u_52_6", 1'b0, 8'h52, 4'h6, 8'h0D, 4'h4, 1'b0, 1'b0, 9);
    runOp("u_6e_7", 1'b0, 8'h6E, 4'h7, 8'h0F, 4'h5, 1'b0, 1'b0, 9);
    runOp("u_f3_5", 1'b0, 8'hF3, 4'h5, 8'h30, 4'h3, 1'b0, 1'b0, 9);
    runOp("u_ff_f", 1'b0, 8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 1'b0, 9);
    runOp("s_m13_5", 1'b1, 8'hF3, 4'h5, 8'hFE, 4'hD, 1'b0, 1'b0, 9);
    runOp("s_13_m5", 1'b1, 8'h0D, 4'hB, 8'hFE, 4'h3, 1'b0, 1'b0, 9);
    runOp("s_m128_m8", 1'b1, 8'h80, 4'h8, 8'h10, 4'h0, 1'b0, 1'b0, 9);
    runOp("dz_25_0", 1'b0, 8'h25, 4'h0, 8'hFF, 4'h0, 1'b1, 1'b0, 1);
    runOp("ov_m128_m1", 1'b1, 8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 9);

    // A start pulse in the middle of CALC must be ignored.
    applyStimulus(1'b0, 8'h52, 4'h6);
    tick(); tick(); tick();
    dividend = 8'h11; divisor = 4'h1; signed_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; dividend = 8'h00; divisor = 4'h0;
    waitDone(lat, busy_bad);
    checkOutput("ignore_latency", lat, 5);
    checkOutput("ignore_q", quotient, 8'h0D);
    checkOutput("ignore_r", remainder, 4'h4);
    tick();

    // Start is held high through done, so a second division launches at once.
    signed_mode = 1'b0; dividend = 8'h0D; divisor = 4'h5; start = 1'b1;
    tick();
    waitDone(lat, busy_bad);
    checkOutput("b2b_first_latency", lat, 9);
    checkOutput("b2b_first_q", quotient, 8'h02);
    checkOutput("b2b_first_r", remainder, 4'h3);
    dividend = 8'h6E; divisor = 4'h7;
    tick();
    start = 1'b0;
    checkOutput("b2b_accept_busy", busy, 1'b1);
    checkOutput("b2b_accept_done", done, 1'b0);
    tick(); tick(); tick();
    checkOutput("b2b_held_q", quotient, 8'h02);
    waitDone(lat, busy_bad);
    checkOutput("b2b_second_latency", lat, 6);
    checkOutput("b2b_second_q", quotient, 8'h0F);
    checkOutput("b2b_second_r", remainder, 4'h5);
    tick();

    // Reset in the middle of an operation clears everything and suppresses done.
    runOp("pre_rst_ov", 1'b1, 8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 9);
    applyStimulus(1'b0, 8'h6E, 4'h7);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_q", quotient, 8'h00);
    checkOutput("midrst_r", remainder, 4'h0);
    checkOutput("midrst_ov", overflow, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    checkOutput("midrst_no_done", done_seen, 0);
    runOp("post_rst_52_6", 1'b0, 8'h52, 4'h6, 8'h0D, 4'h4, 1'b0, 1'b0, 9);

    runOpWide("w_u_1000_7", 1'b0, 16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 1'b0, 17);
    runOpWide("w_s_m1000_7", 1'b1, 16'hFC18, 8'h07, 16'hFF72, 8'hFA, 1'b0, 1'b0, 17);
    runOpWide("w_u_ffff_ff", 1'b0, 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 1'b0, 17);
    runOpWide("w_s_min_2", 1'b1, 16'h8000, 8'h02, 16'hC000, 8'h00, 1'b0, 1'b0, 17);
    runOpWide("w_s_min_m1", 1'b1, 16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 1'b1, 17);
    runOpWide("w_dz", 1'b0, 16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
